// File: rtl/tl_pkg.sv
// Shared definitions for the traffic-light sensor conditioning block:
// state encodings, parameter defaults and phase-timer width.
package tl_pkg;

  localparam int unsigned TMR_W         = 4;
  localparam int unsigned DB_LEN_DEF    = 3;
  localparam int unsigned MIN_GREEN_DEF = 8;
  localparam int unsigned YEL_LEN_DEF   = 4;

  localparam logic [TMR_W-1:0] TMR_MAX = '1;

  typedef enum logic [1:0] {
    S_AG = 2'b00,
    S_AY = 2'b01,
    S_BG = 2'b10,
    S_BY = 2'b11
  } tl_state_e;

  // Increment that holds at the top of the timer range instead of wrapping.
  function automatic logic [TMR_W-1:0] sat_inc(input logic [TMR_W-1:0] v);
    return (v == TMR_MAX) ? v : v + TMR_W'(1);
  endfunction

endpackage

// File: rtl/tl_debounce.sv
// Two-flop synchronizer followed by a run-length debounce filter for one
// asynchronous car sensor.
module tl_debounce
  import tl_pkg::*;
#(
  parameter int unsigned DB_LEN = DB_LEN_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic filt
);

  localparam logic [TMR_W-1:0] DB_LAST = TMR_W'(DB_LEN - 1);

  logic             sync_1;
  logic             sync_2;
  logic [TMR_W-1:0] db_cnt;

  // db_cnt counts consecutive synchronized samples that disagree with filt.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
      filt   <= 1'b0;
      db_cnt <= '0;
    end else begin
      sync_1 <= raw;
      sync_2 <= sync_1;
      if (sync_2 == filt) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        filt   <= ~filt;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + TMR_W'(1);
      end
    end
  end

endmodule

// File: rtl/tl_sensor_cond.sv
// Conditions the two street sensors and times the current light phase to
// produce the traffic inputs and load enable for the light state register.
module tl_sensor_cond
  import tl_pkg::*;
#(
  parameter int unsigned DB_LEN    = DB_LEN_DEF,
  parameter int unsigned MIN_GREEN = MIN_GREEN_DEF,
  parameter int unsigned YEL_LEN   = YEL_LEN_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_a,
  input  logic raw_b,
  input  logic Q1,
  input  logic Q0,
  output logic Ta,
  output logic Tb,
  output logic st_en
);

  if (DB_LEN < 1 || DB_LEN > 15 || MIN_GREEN < 1 || MIN_GREEN > 15 ||
      YEL_LEN < 1 || YEL_LEN > 15) begin : g_param_check
    $error("tl_sensor_cond: parameters must lie in 1..15");
  end

  localparam logic [TMR_W-1:0] MIN_GREEN_T = TMR_W'(MIN_GREEN);
  localparam logic [TMR_W-1:0] YEL_LAST_T  = TMR_W'(YEL_LEN - 1);

  logic [1:0]       q;
  logic [1:0]       prev;
  logic             q_chg;
  logic [TMR_W-1:0] cnt;
  logic [TMR_W-1:0] t;
  logic             filt_a;
  logic             filt_b;

  tl_debounce #(.DB_LEN(DB_LEN)) u_db_a (
    .clk   (clk),
    .reset (reset),
    .raw   (raw_a),
    .filt  (filt_a)
  );

  tl_debounce #(.DB_LEN(DB_LEN)) u_db_b (
    .clk   (clk),
    .reset (reset),
    .raw   (raw_b),
    .filt  (filt_b)
  );

  assign q     = {Q1, Q0};
  assign q_chg = (q != prev);
  assign t     = q_chg ? '0 : cnt;

  // Phase timer: cycles spent in the current state, saturating at TMR_MAX.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev <= S_AG;
      cnt  <= '0;
    end else begin
      prev <= q;
      cnt  <= q_chg ? TMR_W'(1) : sat_inc(cnt);
    end
  end

  // Greens force their own street's traffic until MIN_GREEN has elapsed.
  always_comb begin
    Ta    = filt_a;
    Tb    = filt_b;
    st_en = 1'b0;
    if (q == S_AG && t < MIN_GREEN_T) Ta = 1'b1;
    if (q == S_BG && t < MIN_GREEN_T) Tb = 1'b1;
    if (q == S_AG || q == S_BG) st_en = 1'b1;
    else if (t >= YEL_LAST_T)   st_en = 1'b1;
  end

endmodule

// File: tb/tb_tl_sensor_cond.sv
// Self-checking bench for tl_sensor_cond: directed scenarios plus a random
// run compared against a cycle-level behavioural model.
module tb_tl_sensor_cond;

  localparam int DB_LEN    = 3;
  localparam int MIN_GREEN = 8;
  localparam int YEL_LEN   = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       raw_a;
  logic       raw_b;
  logic [1:0] q;
  logic       ta_s;
  logic       tb_s;
  logic       en_s;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  tl_sensor_cond #(
    .DB_LEN    (DB_LEN),
    .MIN_GREEN (MIN_GREEN),
    .YEL_LEN   (YEL_LEN)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .raw_a (raw_a),
    .raw_b (raw_b),
    .Q1    (q[1]),
    .Q0    (q[0]),
    .Ta    (ta_s),
    .Tb    (tb_s),
    .st_en (en_s)
  );

  // Model: raw samples become visible to the filter two edges after capture;
  // the filter flips after DB_LEN consecutive disagreeing samples.
  bit         hist_a[$];
  bit         hist_b[$];
  int         run_a = 0;
  int         run_b = 0;
  bit         fa = 0;
  bit         fb = 0;
  logic [1:0] last_q = 2'b00;
  int         edge_n = 0;
  int         base_n = 0;

  always @(posedge clk) begin
    bit used;
    edge_n++;
    if (reset) begin
      hist_a = '{0, 0};
      hist_b = '{0, 0};
      run_a = 0; run_b = 0; fa = 0; fb = 0;
      last_q = 2'b00;
      base_n = edge_n;
    end else begin
      used = hist_a.pop_front();
      hist_a.push_back(raw_a);
      if (used != fa) begin
        run_a++;
        if (run_a == DB_LEN) begin fa = !fa; run_a = 0; end
      end else run_a = 0;
      used = hist_b.pop_front();
      hist_b.push_back(raw_b);
      if (used != fb) begin
        run_b++;
        if (run_b == DB_LEN) begin fb = !fb; run_b = 0; end
      end else run_b = 0;
      if (q != last_q) base_n = edge_n - 1;
      last_q = q;
    end
  end

  function automatic int model_t();
    if (q != last_q) return 0;
    return (edge_n - base_n > 15) ? 15 : edge_n - base_n;
  endfunction

  function automatic bit exp_ta();
    return fa || (q == 2'b00 && model_t() < MIN_GREEN);
  endfunction

  function automatic bit exp_tb();
    return fb || (q == 2'b10 && model_t() < MIN_GREEN);
  endfunction

  function automatic bit exp_en();
    return !q[0] || model_t() >= YEL_LEN - 1;
  endfunction

  task automatic drive(input logic r, input logic a, input logic b, input logic [1:0] qq);
    @(negedge clk);
    reset = r; raw_a = a; raw_b = b; q = qq;
    #1;
  endtask

  task automatic test_reset();
    drive(1, 0, 0, 2'b00);
    drive(1, 0, 0, 2'b00);
    drive(0, 0, 0, 2'b00);
    total++; if (ta_s !== 1'b1) begin bad++; $display("FAIL reset_ta: got %b want 1", ta_s); end
    total++; if (tb_s !== 1'b0) begin bad++; $display("FAIL reset_tb: got %b want 0", tb_s); end
    total++; if (en_s !== 1'b1) begin bad++; $display("FAIL reset_en: got %b want 1", en_s); end
  endtask

  task automatic test_glitch();
    for (int i = 0; i < 10; i++) drive(0, 0, 0, 2'b00);
    for (int i = 0; i < 12; i++) begin
      drive(0, logic'(i < 2), 0, 2'b00);
      total++;
      if (ta_s !== 1'b0 || ta_s !== exp_ta()) begin
        bad++; $display("FAIL glitch_ta i=%0d: got %b want 0", i, ta_s);
      end
    end
  endtask

  task automatic test_debounce_latency();
    for (int i = 0; i < 10; i++) drive(0, 0, 0, 2'b10);
    for (int i = 0; i < 7; i++) begin
      drive(0, 0, 1, 2'b10);
      total++;
      if (tb_s !== logic'(i >= 5) || tb_s !== exp_tb()) begin
        bad++; $display("FAIL latency_tb i=%0d: got %b want %b", i, tb_s, i >= 5);
      end
    end
  endtask

  task automatic test_min_green();
    for (int i = 0; i < 10; i++) begin
      drive(0, 0, 1, 2'b00);
      total++;
      if (ta_s !== logic'(i < MIN_GREEN) || ta_s !== exp_ta()) begin
        bad++; $display("FAIL min_green_ta t=%0d: got %b want %b", i, ta_s, i < MIN_GREEN);
      end
    end
  endtask

  task automatic test_yellow_hold();
    for (int i = 0; i <= 20; i++) begin
      drive(0, 0, 1, 2'b01);
      total++;
      if (en_s !== logic'(i >= YEL_LEN - 1) || en_s !== exp_en()) begin
        bad++; $display("FAIL yellow_en t=%0d: got %b want %b", i, en_s, i >= YEL_LEN - 1);
      end
    end
  endtask

  task automatic test_reset_mid_yellow();
    drive(0, 0, 0, 2'b00);
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 2'b01);
      total++;
      if (en_s !== 1'b0) begin bad++; $display("FAIL midyel_pre_en t=%0d: got %b want 0", i, en_s); end
    end
    drive(1, 0, 0, 2'b01);
    for (int i = 0; i < 10; i++) begin
      drive(0, 0, 0, 2'b00);
      total++;
      if (ta_s !== logic'(i < MIN_GREEN) || ta_s !== exp_ta()) begin
        bad++; $display("FAIL midyel_ta t=%0d: got %b want %b", i, ta_s, i < MIN_GREEN);
      end
      total++;
      if (en_s !== 1'b1 || tb_s !== 1'b0) begin
        bad++; $display("FAIL midyel_en_tb t=%0d: got en=%b tb=%b want en=1 tb=0", i, en_s, tb_s);
      end
    end
  endtask

  task automatic test_random();
    logic       a = 0, b = 0, r;
    logic [1:0] qq = 2'b00;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 99) < 15) a = !a;
      if ($urandom_range(0, 99) < 15) b = !b;
      if ($urandom_range(0, 99) < 6)  qq = 2'($urandom_range(0, 3));
      r = logic'($urandom_range(0, 199) == 0);
      drive(r, a, b, qq);
      total++;
      if (ta_s !== exp_ta() || tb_s !== exp_tb() || en_s !== exp_en()) begin
        bad++;
        $display("FAIL random n=%0d: got Ta=%b Tb=%b en=%b want Ta=%b Tb=%b en=%b",
                 n, ta_s, tb_s, en_s, exp_ta(), exp_tb(), exp_en());
      end
    end
  endtask

  initial begin
    hist_a = '{0, 0};
    hist_b = '{0, 0};
    reset = 1'b1; raw_a = 1'b0; raw_b = 1'b0; q = 2'b00;
    test_reset();
    test_glitch();
    test_debounce_latency();
    test_min_green();
    test_yellow_hold();
    test_reset_mid_yellow();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tl_sensor_cond.md
TL_SENSOR_COND -- requirements
Module: tl_sensor_cond

Interface
REQ-001 SHALL have parameter DB_LEN, default 3: consecutive agreeing synchronized samples needed to change a filtered sensor value.
REQ-002 SHALL have parameter MIN_GREEN, default 8: minimum cycles a green state is held regardless of sensor.
REQ-003 SHALL have parameter YEL_LEN, default 4: cycles a yellow state is held.
REQ-004 SHALL use one clock and a synchronous, active-high reset.
REQ-005 clk  input  1  sole clock; all registers update on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 raw_a  input  1  asynchronous street-A car sensor; 1 means traffic.
REQ-008 raw_b  input  1  asynchronous street-B car sensor; 1 means traffic.
REQ-009 Q1, Q0  input  1 each  current traffic-light state from the state register.
REQ-010 Ta  output  1  conditioned street-A traffic signal to the next-state logic.
REQ-011 Tb  output  1  conditioned street-B traffic signal to the next-state logic.
REQ-012 st_en  output  1  load enable for the state register.

Function
REQ-013 State encoding {Q1,Q0} SHALL be: 00 A-green, 01 A-yellow, 10 B-green, 11 B-yellow.
REQ-014 Each raw input SHALL pass through a 2-flop synchronizer before any other use.
REQ-015 Debounce: filtered value SHALL flip on the edge where the DB_LEN-th consecutive synchronized sample differing from it is captured; any agreeing sample clears the disagree count.
REQ-016 Latency: raw input changing before edge k and held stable SHALL flip the filtered value at edge k+1+DB_LEN; pulses shorter than DB_LEN synchronized cycles SHALL be ignored.
REQ-017 Phase timer: register prev samples {Q1,Q0} every cycle; t = 0 when {Q1,Q0} != prev, else t = cnt.
REQ-018 cnt SHALL update as: 1 when {Q1,Q0} != prev, else cnt+1, saturating at 15 (4-bit); wrap-around is forbidden.
REQ-019 Ta SHALL be filt_a OR ({Q1,Q0}==00 AND t < MIN_GREEN); Tb SHALL be filt_b OR ({Q1,Q0}==10 AND t < MIN_GREEN).
REQ-020 st_en SHALL be 1 in green states and 1 in yellow states only when t >= YEL_LEN-1; otherwise it SHALL be 0.
REQ-021 Ta, Tb, st_en SHALL be combinational from registers and Q1/Q0; there is no added output register stage.
REQ-022 Both sensors active at once SHALL not interact; each path is independent.
REQ-023 A state change during debounce SHALL not disturb the debounce counters.
REQ-024 Parameters SHALL satisfy 1 <= DB_LEN <= 15, 1 <= MIN_GREEN <= 15, 1 <= YEL_LEN <= 15.

Reset
REQ-025 While reset=1 at an edge: synchronizer flops, filtered values, debounce counts and cnt SHALL clear to 0, and prev SHALL load 00.
REQ-026 After reset with {Q1,Q0}=00, outputs SHALL be Ta=1, Tb=0, st_en=1.
REQ-027 Reset asserted mid-operation SHALL abort debounce and phase timing immediately; no residual counts survive.

Structure
REQ-028 Shared package tl_pkg SHALL hold the state encodings S_AG, S_AY, S_BG, S_BY, the parameter defaults, and the timer width (4).
REQ-029 Synchronizer and debounce SHALL be one sub-module, tl_debounce, instantiated once per sensor.
REQ-030 Phase timer and output logic SHALL reside in tl_sensor_cond.
REQ-031 Expected size is 120-400 RTL lines.

Verification
REQ-032 Reset: reset=1 for 2 edges with Q=00, raw=0 -> Ta=1, Tb=0, st_en=1 on release.
REQ-033 Glitch: raw_a=1 for 2 cycles then 0, Q=00, t>=8 -> Ta stays 0 throughout.
REQ-034 Debounce latency: Q=10, t>=8, raw_b 0->1 before edge 10 and held -> Tb=1 after edge 14 and not before.
REQ-035 Min green: Q changes to 00, raw_a=0 -> Ta=1 for t=0..7, Ta=0 at t=8.
REQ-036 Yellow hold: Q changes to 01 -> st_en=0 at t=0..2, st_en=1 at t=3; bench holds Q=01 to t=20 -> st_en stays 1 with cnt saturated at 15.
REQ-037 Reset mid-yellow: Q=01 at t=2, reset pulse, then Q=00 -> t restarts at 0, Ta=1, st_en=1.
